// File: rtl/serial_mag_compare.sv
// serial_mag_compare: cascadable unsigned comparator that walks the operands
// one 2-bit digit per clock from the MSB and stops at the first differing digit.
module serial_mag_compare #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             eq_in,
  input  logic             gt_in,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt
);
  localparam int D  = WIDTH / 2;
  localparam int IW = (D > 1) ? $clog2(D) : 1;

  typedef enum logic {IDLE, COMPARE} state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            ceq_q, ceq_d, cgt_q, cgt_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic            eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;
  logic [1:0]      da, db;
  logic            fin;

  assign da  = op_a_q[{idx_q, 1'b0} +: 2];
  assign db  = op_b_q[{idx_q, 1'b0} +: 2];
  // A cleared cascade-equal decides the result without looking at any digit.
  assign fin = !ceq_q || (da != db) || (idx_q == '0);

  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    idx_d   = idx_q;
    ceq_d   = ceq_q;
    cgt_d   = cgt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    eq_d    = eq_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    if (state_q == IDLE) begin
      if (start) begin
        op_a_d  = a;
        op_b_d  = b;
        ceq_d   = eq_in;
        cgt_d   = gt_in;
        idx_d   = IW'(D - 1);
        busy_d  = 1'b1;
        state_d = COMPARE;
      end
    end else if (fin) begin
      eq_d    = ceq_q && (da == db);
      gt_d    = ceq_q ? (da > db) : cgt_q;
      lt_d    = ceq_q ? (da < db) : !cgt_q;
      done_d  = 1'b1;
      busy_d  = 1'b0;
      state_d = IDLE;
    end else begin
      idx_d = idx_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      idx_q   <= '0;
      ceq_q   <= 1'b0;
      cgt_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      idx_q   <= idx_d;
      ceq_q   <= ceq_d;
      cgt_q   <= cgt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign eq   = eq_q;
  assign gt   = gt_q;
  assign lt   = lt_q;
endmodule

// File: tb/tb_serial_mag_compare.sv
// tb_serial_mag_compare: directed and random compares checked against an
// arithmetic reference for result and digit-count latency.
module tb_serial_mag_compare;
  localparam int W = 8;
  localparam int D = W / 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         eq_in = 1'b0, gt_in = 1'b0;
  logic         busy, done, eq, gt, lt;
  logic         p_eq = 1'b0, p_gt = 1'b0, p_lt = 1'b0;
  int           n_cmp = 0, n_bad = 0;

  serial_mag_compare #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .eq_in(eq_in), .gt_in(gt_in), .busy(busy), .done(done),
    .eq(eq), .gt(gt), .lt(lt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Digits examined: 1 for a cleared cascade, else up to the highest differing digit.
  function automatic int exp_k(input logic [W-1:0] x, input logic [W-1:0] y, input logic ei);
    logic [W-1:0] d;
    d = x ^ y;
    if (!ei) return 1;
    if (d == '0) return D;
    for (int h = W - 1; h >= 0; h--)
      if (d[h]) return D - h / 2;
    return D;
  endfunction

  task automatic hold_check(input string tag);
    chk({tag, "_eq_hold"}, eq, p_eq);
    chk({tag, "_gt_hold"}, gt, p_gt);
    chk({tag, "_lt_hold"}, lt, p_lt);
  endtask

  // Called either right after a posedge (+1) or before any edge; start is sampled at the next edge.
  task automatic run(input logic [W-1:0] x, input logic [W-1:0] y, input logic ei,
                     input logic gi, input logic glitch);
    int  k, n;
    logic xeq, xgt, xlt;
    k   = exp_k(x, y, ei);
    xeq = ei && (x == y);
    xgt = ei ? (x > y) : gi;
    xlt = ei ? (x < y) : !gi;
    a = x; b = y; eq_in = ei; gt_in = gi; start = 1'b1;
    @(posedge clk); #1;
    chk("busy_after_accept", busy, 1'b1);
    chk("done_after_accept", done, 1'b0);
    hold_check("accept");
    a = W'($urandom); b = W'($urandom); eq_in = 1'($urandom); gt_in = 1'($urandom);
    start = glitch;
    n = 0;
    while (!done && n < D + 2) begin
      @(posedge clk); #1;
      start = 1'b0;
      n++;
      if (!done) chk("busy_mid", busy, 1'b1);
    end
    chk("latency", n, k);
    chk("done_pulse", done, 1'b1);
    chk("busy_at_done", busy, 1'b0);
    chk("eq", eq, xeq);
    chk("gt", gt, xgt);
    chk("lt", lt, xlt);
    p_eq = xeq; p_gt = xgt; p_lt = xlt;
  endtask

  task automatic idle_check;
    @(posedge clk); #1;
    chk("done_one_cycle", done, 1'b0);
    chk("busy_idle", busy, 1'b0);
    hold_check("idle");
  endtask

  initial begin
    logic [W-1:0] x, y;
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    hold_check("rst");
    @(negedge clk); rst_n = 1'b1;
    run(8'hA5, 8'hA5, 1'b1, 1'b0, 1'b0); idle_check();
    run(8'hC0, 8'h80, 1'b1, 1'b0, 1'b0); idle_check();
    run(8'h12, 8'h13, 1'b1, 1'b0, 1'b0); idle_check();
    run(8'h00, 8'hFF, 1'b0, 1'b1, 1'b0); idle_check();
    run(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0); idle_check();
    run(8'h5A, 8'h5A, 1'b1, 1'b0, 1'b1);
    run(8'h40, 8'h7F, 1'b1, 1'b0, 1'b0); idle_check();
    // Reset abandons an in-flight compare.
    a = 8'h3C; b = 8'h3C; eq_in = 1'b1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0; #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    p_eq = 1'b0; p_gt = 1'b0; p_lt = 1'b0;
    hold_check("arst");
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < D + 2; i++) begin
      @(posedge clk); #1;
      chk("no_done_after_rst", done, 1'b0);
    end
    hold_check("post_rst");
    for (int i = 0; i < 40; i++) begin
      x = W'($urandom);
      y = ($urandom_range(0, 3) == 0) ? x : W'($urandom);
      if ($urandom_range(0, 2) == 0) y = {x[W-1:2], 2'($urandom)};
      run(x, y, $urandom_range(0, 4) != 0, 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 0) idle_check();
    end
    idle_check();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
